// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a FIFO in front of it, back-to-back frames and optional parity
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 135,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic i_Clock,
  input logic i_Reset,
  input logic i_Tx_DV,
  input logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic o_Overflow,
  output logic o_Tx_Active,
  output logic o_Tx_Serial,
  output logic o_Tx_Done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] clk_q, clk_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic par_q, par_d, serial_q, serial_d, done_q, done_d, active_q, active_d, ovf_q, ovf_d;
  logic full, push, pop, tick;
  always_comb begin
    full = count_q == (AW+1)'(FIFO_DEPTH);
    push = i_Tx_DV && !full;
    tick = clk_q == CW'(CLKS_PER_BIT - 1);
    pop = 1'b0;
    state_d = state_q;
    clk_d = tick ? '0 : clk_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    case (state_q)
      S_IDLE: begin
        clk_d = '0;
        if (count_q != '0) begin
          pop = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        bit_d = '0;
      end
      S_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'(DATA_BITS - 1)) begin
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          bit_d = '0;
        end
      end
      S_PARITY: if (tick) begin
        state_d = S_STOP;
        bit_d = '0;
      end
      S_STOP: if (tick) begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'(STOP_BITS - 1)) begin
          bit_d = '0;
          pop = count_q != '0;
          state_d = (count_q != '0) ? S_START : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        clk_d = '0;
        bit_d = '0;
      end
    endcase
    shift_d = pop ? mem[rd_q] : shift_d;
    par_d = pop ? ((PARITY == 1) ? ~^mem[rd_q] : ^mem[rd_q]) : par_d;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    serial_d = (state_d == S_START) ? 1'b0 : (state_d == S_DATA) ? shift_d[0] : (state_d == S_PARITY) ? par_d : 1'b1;
    done_d = state_d == S_STOP && clk_d == CW'(CLKS_PER_BIT - 1) && bit_d == 4'(STOP_BITS - 1);
    active_d = state_d != S_IDLE;
    ovf_d = i_Tx_DV && full;
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      clk_q <= '0;
      bit_q <= '0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      serial_q <= 1'b1;
      done_q <= 1'b0;
      active_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q <= clk_d;
      bit_q <= bit_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      shift_q <= shift_d;
      par_q <= par_d;
      serial_q <= serial_d;
      done_q <= done_d;
      active_q <= active_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && push) mem[wr_q] <= i_Tx_Byte;
  end
  assign o_Tx_Ready = !full;
  assign o_Fifo_Count = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done = done_q;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 135: clock cycles per serial bit; legal range 2..2047.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: 1 or 2 stop bits.
REQ-005 Parameter FIFO_DEPTH, default 16: transmit FIFO entries; power of two, 2..256.
REQ-006 i_Clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 i_Reset  in  1  reset, synchronous to i_Clock and active-high.
REQ-008 i_Tx_DV  in  1  write strobe; one FIFO push per cycle high.
REQ-009 i_Tx_Byte  in  DATA_BITS  word to transmit; sampled when i_Tx_DV is high.
REQ-010 o_Tx_Ready  out  1  high when FIFO count < FIFO_DEPTH.
REQ-011 o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 o_Overflow  out  1  one-cycle pulse when a push is dropped.
REQ-013 o_Tx_Active  out  1  high while any frame is on the line.
REQ-014 o_Tx_Serial  out  1  registered serial line; idle high.
REQ-015 o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-016 FIFO push: when i_Tx_DV=1 and the count is below FIFO_DEPTH at that edge, store i_Tx_Byte; with the FIFO full, drop the word and pulse o_Overflow the next cycle.
REQ-017 When full, a push is rejected even if a pop occurs in the same cycle; a simultaneous accepted push and a pop leave the count unchanged.
REQ-018 Order is first-in first-out, and pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP; any unused encoding returns to IDLE.
REQ-020 IDLE: o_Tx_Serial=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
REQ-021 START: o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles, starting the cycle after the pop.
REQ-022 DATA: send DATA_BITS bits LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-023 DATA exit: go to PARITY if PARITY != 0, otherwise to STOP.
REQ-024 PARITY: hold one bit for CLKS_PER_BIT cycles; odd = ~^data, even = ^data.
REQ-025 STOP: o_Tx_Serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-026 Last STOP cycle: pulse o_Tx_Done for one cycle.
REQ-027 STOP exit with FIFO non-empty: pop and enter START on the next cycle with no idle gap, so frames are back-to-back.
REQ-028 STOP exit with FIFO empty: enter IDLE.
REQ-029 Frame length is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
REQ-030 o_Tx_Active rises with the first START cycle and falls the cycle after the final STOP cycle; it stays high across back-to-back frames.
REQ-031 The bit counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1 and clears at every bit boundary.
REQ-032 A word is consumed only by a pop; i_Tx_Byte changes after acceptance do not affect the frame in progress.

Reset
REQ-033 While i_Reset=1 at an edge:
  - FSM goes to IDLE and the FIFO is emptied (o_Fifo_Count=0).
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Tx_Ready=1.
  - Counters clear.
REQ-034 Reset mid-frame abandons the frame: o_Tx_Serial is high from the cycle after the reset edge, and no o_Tx_Done pulse is produced.
REQ-035 A push presented with i_Reset=1 is ignored.

Verification (bench uses CLKS_PER_BIT=4)
REQ-036 8N1, push 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; o_Tx_Done pulses once at cycle 40; o_Tx_Active high 40 cycles.
REQ-037 8E1, push 0xA5 -> parity bit 0; 8O1 -> parity bit 1; frame 44 cycles.
REQ-038 Push 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames with no idle cycle between them; o_Tx_Active continuous 120 cycles; three o_Tx_Done pulses.
REQ-039 FIFO_DEPTH=4, push 6 words while the line is busy -> o_Tx_Ready low at count 4, one o_Overflow pulse per dropped word, sent data matches accepted words in order.
REQ-040 Assert i_Reset during bit 3 of a frame with 2 words queued -> line high the next cycle, count 0, no o_Tx_Done, line idle after reset release.
REQ-041 DATA_BITS=7, STOP_BITS=2, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then stop held 8 cycles; frame 40 cycles.
